toggle_bank: RTL and testbench

TOGGLE_BANK -- requirements
Module: toggle_bank

---
 rtl/toggle_bank.sv | 156 +++++++++++++++
 tb/tb_toggle_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_bank.sv
// Bank of NCH independent toggle generators. Each channel has a prescaler and
// runs either once (sticky done) or continuously (wrap pulse on every reload).
module toggle_bank #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 32,
  parameter int DIV_W     = 16,
  parameter int DEF_COUNT = 100000,
  localparam int CW       = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_count,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   wrap,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chState_e;

  logic [WIDTH-1:0] countReg_q  [NCH];
  logic [WIDTH-1:0] countReg_d  [NCH];
  logic [DIV_W-1:0] divReg_q    [NCH];
  logic [DIV_W-1:0] divReg_d    [NCH];
  logic [WIDTH-1:0] remaining_q [NCH];
  logic [WIDTH-1:0] remaining_d [NCH];
  logic [DIV_W-1:0] presc_q     [NCH];
  logic [DIV_W-1:0] presc_d     [NCH];
  chState_e         state_q     [NCH];
  chState_e         state_d     [NCH];

  logic [NCH-1:0] modeReg_q, modeReg_d;
  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] wrap_q, wrap_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic           cfgErr_q, cfgErr_d;
  logic [NCH-1:0] writeOk;

  // An out-of-range channel matches no bit, so it falls through to the error pulse.
  always_comb begin
    writeOk = '0;
    for (int i = 0; i < NCH; i++) begin
      writeOk[i] = cfg_we && (cfg_ch == CW'(i)) && (state_q[i] != RUN);
    end
  end

  assign cfgErr_d = cfg_we && (writeOk == '0);

  always_comb begin
    level_d   = level_q;
    done_d    = done_q;
    modeReg_d = modeReg_q;
    wrap_d    = '0;
    busy_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      countReg_d[i]  = countReg_q[i];
      divReg_d[i]    = divReg_q[i];
      remaining_d[i] = remaining_q[i];
      presc_d[i]     = presc_q[i];
      state_d[i]     = state_q[i];

      if (writeOk[i]) begin
        countReg_d[i] = cfg_count;
        divReg_d[i]   = cfg_div;
        modeReg_d[i]  = cfg_mode;
      end

      // Starts read the registered config, so a same-cycle write applies next run.
      if (stop[i]) begin
        state_d[i] = IDLE;
        level_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end else if (start[i] && (state_q[i] != RUN)) begin
        level_d[i] = 1'b0;
        if (countReg_q[i] == '0) begin
          state_d[i]     = DONE;
          done_d[i]      = 1'b1;
          remaining_d[i] = '0;
        end else begin
          state_d[i]     = RUN;
          done_d[i]      = 1'b0;
          remaining_d[i] = countReg_q[i];
          presc_d[i]     = divReg_q[i];
        end
      end else if (state_q[i] == RUN) begin
        if (presc_q[i] != '0) begin
          presc_d[i] = presc_q[i] - DIV_W'(1);
        end else begin
          level_d[i] = ~level_q[i];
          presc_d[i] = divReg_q[i];
          if (remaining_q[i] > WIDTH'(1)) begin
            remaining_d[i] = remaining_q[i] - WIDTH'(1);
          end else if (modeReg_q[i]) begin
            remaining_d[i] = countReg_q[i];
            wrap_d[i]      = 1'b1;
          end else begin
            remaining_d[i] = '0;
            state_d[i]     = DONE;
            done_d[i]      = 1'b1;
          end
        end
      end

      busy_d[i] = (state_d[i] == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        countReg_q[i]  <= WIDTH'(DEF_COUNT);
        divReg_q[i]    <= '0;
        remaining_q[i] <= '0;
        presc_q[i]     <= '0;
        state_q[i]     <= IDLE;
      end
      modeReg_q <= '0;
      level_q   <= '0;
      done_q    <= '0;
      wrap_q    <= '0;
      busy_q    <= '0;
      cfgErr_q  <= 1'b0;
    end else begin
      countReg_q  <= countReg_d;
      divReg_q    <= divReg_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      state_q     <= state_d;
      modeReg_q   <= modeReg_d;
      level_q     <= level_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign out     = level_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wrap    = wrap_q;
  assign cfg_err = cfgErr_q;

endmodule

// File: tb/tb_toggle_bank.sv
// Directed bench for toggle_bank, built with three channels so channel index 3 is out of range
// and with a short reset count so a full default-count run fits in the simulation.
module tb_toggle_bank;

  localparam int NCH       = 3;
  localparam int WIDTH     = 32;
  localparam int DIV_W     = 16;
  localparam int DEF_COUNT = 37;
  localparam int CW        = $clog2(NCH);

  logic             clk = 1'b0;
  logic             reset;
  logic             cfgWe;
  logic [CW-1:0]    cfgCh;
  logic [WIDTH-1:0] cfgCount;
  logic [DIV_W-1:0] cfgDiv;
  logic             cfgMode;
  logic [NCH-1:0]   startV;
  logic [NCH-1:0]   stopV;
  logic [NCH-1:0]   outV;
  logic [NCH-1:0]   busyV;
  logic [NCH-1:0]   doneV;
  logic [NCH-1:0]   wrapV;
  logic             cfgErr;

  int compareCount = 0;
  int failCount    = 0;
  int toggles;
  logic prevOut;

  toggle_bank #(
    .NCH(NCH), .WIDTH(WIDTH), .DIV_W(DIV_W), .DEF_COUNT(DEF_COUNT)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfgWe), .cfg_ch(cfgCh), .cfg_count(cfgCount),
    .cfg_div(cfgDiv), .cfg_mode(cfgMode), .start(startV), .stop(stopV),
    .out(outV), .busy(busyV), .done(doneV), .wrap(wrapV), .cfg_err(cfgErr)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input logic [CW-1:0] ch, input logic [WIDTH-1:0] cnt,
                          input logic [DIV_W-1:0] dv, input logic md);
    cfgWe = 1'b1; cfgCh = ch; cfgCount = cnt; cfgDiv = dv; cfgMode = md;
    applyStimulus(1);
    cfgWe = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfgWe = 1'b0; cfgCh = '0; cfgCount = '0; cfgDiv = '0; cfgMode = 1'b0;
    startV = '0; stopV = '0;
    applyStimulus(2);
    checkOutput("rst_out", 32'(outV), 32'd0);
    checkOutput("rst_busy", 32'(busyV), 32'd0);
    checkOutput("rst_done", 32'(doneV), 32'd0);
    checkOutput("rst_wrap", 32'(wrapV), 32'd0);
    checkOutput("rst_cfgerr", 32'(cfgErr), 32'd0);
    reset = 1'b1;

    // One-shot, no prescale
    cfgWrite(2'd0, 32'd4, 16'd0, 1'b0);
    checkOutput("os_cfgerr", 32'(cfgErr), 32'd0);
    startV[0] = 1'b1; applyStimulus(1); startV[0] = 1'b0;
    checkOutput("os_busy_e0", 32'(busyV[0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("os_out_e%0d", k), 32'(outV[0]), 32'(k % 2));
      checkOutput($sformatf("os_done_e%0d", k), 32'(doneV[0]), (k == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("os_busy_e%0d", k), 32'(busyV[0]), (k == 4) ? 32'd0 : 32'd1);
    end

    // Prescaled one-shot
    cfgWrite(2'd1, 32'd2, 16'd2, 1'b0);
    startV[1] = 1'b1; applyStimulus(1); startV[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("ps_out_e%0d", k), 32'(outV[1]), (k >= 3 && k < 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ps_done_e%0d", k), 32'(doneV[1]), (k == 6) ? 32'd1 : 32'd0);
    end

    // Continuous with a rejected write to the running channel at E5
    cfgWrite(2'd2, 32'd3, 16'd0, 1'b1);
    startV[2] = 1'b1; applyStimulus(1); startV[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) begin
        cfgWe = 1'b1; cfgCh = 2'd2; cfgCount = 32'd7; cfgDiv = 16'd5; cfgMode = 1'b0;
      end
      applyStimulus(1);
      cfgWe = 1'b0;
      checkOutput($sformatf("ct_wrap_e%0d", k), 32'(wrapV[2]), (k % 3 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ct_busy_e%0d", k), 32'(busyV[2]), 32'd1);
      checkOutput($sformatf("ct_out_e%0d", k), 32'(outV[2]), 32'(k % 2));
      checkOutput($sformatf("ct_cfgerr_e%0d", k), 32'(cfgErr), (k == 5) ? 32'd1 : 32'd0);
    end
    stopV[2] = 1'b1; applyStimulus(1); stopV[2] = 1'b0;
    checkOutput("ct_stop_out", 32'(outV[2]), 32'd0);
    checkOutput("ct_stop_busy", 32'(busyV[2]), 32'd0);
    checkOutput("ct_stop_wrap", 32'(wrapV[2]), 32'd0);

    // Out-of-range channel write leaves channel 0 at count 4
    cfgWrite(2'd3, 32'd1, 16'd0, 1'b0);
    checkOutput("oor_cfgerr", 32'(cfgErr), 32'd1);
    startV[0] = 1'b1; applyStimulus(1); startV[0] = 1'b0;
    checkOutput("oor_cfgerr_clr", 32'(cfgErr), 32'd0);
    applyStimulus(1);
    checkOutput("oor_done_e1", 32'(doneV[0]), 32'd0);
    applyStimulus(3);
    checkOutput("oor_done_e4", 32'(doneV[0]), 32'd1);
    checkOutput("oor_out_e4", 32'(outV[0]), 32'd0);

    // Zero count goes straight to DONE
    cfgWrite(2'd1, 32'd0, 16'd0, 1'b0);
    startV[1] = 1'b1; applyStimulus(1); startV[1] = 1'b0;
    checkOutput("z_done", 32'(doneV[1]), 32'd1);
    checkOutput("z_busy", 32'(busyV[1]), 32'd0);
    checkOutput("z_out", 32'(outV[1]), 32'd0);
    applyStimulus(1);
    checkOutput("z_out_hold", 32'(outV[1]), 32'd0);
    checkOutput("z_done_hold", 32'(doneV[1]), 32'd1);

    // Start and stop together on a DONE channel
    startV[0] = 1'b1; stopV[0] = 1'b1; applyStimulus(1); startV[0] = 1'b0; stopV[0] = 1'b0;
    checkOutput("ss_busy", 32'(busyV[0]), 32'd0);
    checkOutput("ss_done", 32'(doneV[0]), 32'd0);
    applyStimulus(1);
    checkOutput("ss_out", 32'(outV[0]), 32'd0);

    // Stop coincident with the final toggle
    cfgWrite(2'd1, 32'd1, 16'd0, 1'b0);
    startV[1] = 1'b1; applyStimulus(1); startV[1] = 1'b0;
    checkOutput("sf_busy_e0", 32'(busyV[1]), 32'd1);
    stopV[1] = 1'b1; applyStimulus(1); stopV[1] = 1'b0;
    checkOutput("sf_done", 32'(doneV[1]), 32'd0);
    checkOutput("sf_out", 32'(outV[1]), 32'd0);
    checkOutput("sf_busy", 32'(busyV[1]), 32'd0);

    // Same-cycle write and start: first run uses count 1, next run count 3
    cfgWe = 1'b1; cfgCh = 2'd1; cfgCount = 32'd3; cfgDiv = 16'd0; cfgMode = 1'b0;
    startV[1] = 1'b1; applyStimulus(1); startV[1] = 1'b0; cfgWe = 1'b0;
    checkOutput("wc_cfgerr", 32'(cfgErr), 32'd0);
    checkOutput("wc_busy", 32'(busyV[1]), 32'd1);
    applyStimulus(1);
    checkOutput("wc_done_old", 32'(doneV[1]), 32'd1);
    checkOutput("wc_out_old", 32'(outV[1]), 32'd1);
    startV[1] = 1'b1; applyStimulus(1); startV[1] = 1'b0;
    applyStimulus(2);
    checkOutput("wc_done_e2", 32'(doneV[1]), 32'd0);
    applyStimulus(1);
    checkOutput("wc_done_new", 32'(doneV[1]), 32'd1);
    checkOutput("wc_out_new", 32'(outV[1]), 32'd1);

    // Reset in the middle of a run
    cfgWrite(2'd0, 32'd10, 16'd0, 1'b0);
    startV[0] = 1'b1; applyStimulus(1); startV[0] = 1'b0;
    applyStimulus(3);
    reset = 1'b0; applyStimulus(1);
    checkOutput("mr_out", 32'(outV), 32'd0);
    checkOutput("mr_busy", 32'(busyV), 32'd0);
    checkOutput("mr_done", 32'(doneV), 32'd0);
    checkOutput("mr_wrap", 32'(wrapV), 32'd0);
    checkOutput("mr_cfgerr", 32'(cfgErr), 32'd0);
    reset = 1'b1; startV[0] = 1'b1; applyStimulus(1); startV[0] = 1'b0;
    checkOutput("mr_first_start", 32'(busyV[0]), 32'd1);
    toggles = 0;
    prevOut = 1'b0;
    for (int k = 1; k <= DEF_COUNT; k++) begin
      applyStimulus(1);
      if (outV[0] !== prevOut) toggles++;
      prevOut = outV[0];
      if (k == DEF_COUNT - 1) begin
        checkOutput("mr_done_early", 32'(doneV[0]), 32'd0);
        checkOutput("mr_busy_early", 32'(busyV[0]), 32'd1);
      end
    end
    checkOutput("mr_done_final", 32'(doneV[0]), 32'd1);
    checkOutput("mr_busy_final", 32'(busyV[0]), 32'd0);
    checkOutput("mr_out_final", 32'(outV[0]), 32'(DEF_COUNT % 2));
    checkOutput("mr_toggles", 32'(toggles), 32'(DEF_COUNT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
